// File: rtl/uart_frame_parser_pkg.sv
// ---------------------------------------------------------------------------
// uart_frame_parser_pkg
// Shared types for the UART command front end of the matrix-vector processor:
// the FIFO byte type, frame delimiters, command / state / error encodings and
// a helper that gives the legal length byte for each command.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_frame_parser_pkg;

  typedef logic [7:0] data_t;

  localparam data_t FRAME_HDR = 8'hFE;
  localparam data_t FRAME_END = 8'hEF;

  typedef enum logic [7:0] {
    CMD_SET_N  = 8'h01,
    CMD_START  = 8'h02,
    CMD_LOAD_B = 8'h03,
    CMD_LOAD_A = 8'h04
  } parser_cmd_e;

  typedef enum logic [2:0] {
    ST_WAIT_HDR,
    ST_GET_LEN,
    ST_GET_CMD,
    ST_GET_DATA,
    ST_GET_END
  } parser_state_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_BAD_LEN   = 3'd1,
    ERR_BAD_CMD   = 3'd2,
    ERR_BAD_END   = 3'd3,
    ERR_FULL      = 3'd4,
    ERR_NOT_READY = 3'd5,
    ERR_TIMEOUT   = 3'd6,
    ERR_BAD_N     = 3'd7
  } parser_err_e;

  function automatic logic cmd_known(input data_t b);
    return (b >= 8'h01) && (b <= 8'h04);
  endfunction

  // The length byte covers the command byte plus its payload.
  function automatic data_t expected_len(input data_t cmd, input logic [3:0] n);
    data_t n8;
    n8 = {4'b0000, n};
    case (cmd)
      CMD_SET_N:  return 8'd2;
      CMD_START:  return 8'd1;
      CMD_LOAD_B: return n8 + 8'd1;
      default:    return (n8 * n8) + 8'd1;
    endcase
  endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// ---------------------------------------------------------------------------
// uart_frame_parser_if
// Bundles the byte stream from the UART receiver, the FIFO/processor status
// inputs and the parser's FIFO push / control outputs.
//   master : parser side (drives push_A, push_B, data, N, start, busy, err,
//            err_code; receives rx_data, rx_valid, full_A, full_B, proc_ready)
//   slave  : environment side (the reverse directions)
// ---------------------------------------------------------------------------
interface uart_frame_parser_if;
  import uart_frame_parser_pkg::*;

  data_t       rx_data;
  logic        rx_valid;
  logic        full_A;
  logic        full_B;
  logic        proc_ready;
  logic        push_A;
  logic        push_B;
  data_t       data;
  logic [3:0]  N;
  logic        start;
  logic        busy;
  logic        err;
  logic [2:0]  err_code;

  modport master (
    input  rx_data, rx_valid, full_A, full_B, proc_ready,
    output push_A, push_B, data, N, start, busy, err, err_code
  );

  modport slave (
    output rx_data, rx_valid, full_A, full_B, proc_ready,
    input  push_A, push_B, data, N, start, busy, err, err_code
  );

endinterface

// File: rtl/byte_timeout_counter.sv
// ---------------------------------------------------------------------------
// byte_timeout_counter
// Counts idle cycles between received bytes while a frame is open.
//   clk, rst : clock, asynchronous active-high reset
//   load     : a byte arrived this cycle, restart the count
//   enable   : a frame is in progress; count is held at zero otherwise
//   expire   : the gap since the last byte has reached LIMIT cycles
// ---------------------------------------------------------------------------
module byte_timeout_counter #(
  parameter int LIMIT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign expire = enable && !load && (cnt == W'(LIMIT - 1));

  // Count only inside a frame; any new byte or leaving the frame restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || !enable) begin
      cnt <= '0;
    end else if (!expire) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser
// Decodes framed commands (FE, L, CMD, payload, EF) from the UART byte stream
// and turns them into FIFO A/B pushes, the matrix order N and a start strobe.
// Bad frames abort with a one-cycle err pulse and a sticky err_code.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uart_frame_parser_if.master (byte input, FIFO/processor status,
//              push/data/N/start/busy/err/err_code outputs)
// Optional feature: define PARSER_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYCLES idle cycles between bytes (error code 6).
// ---------------------------------------------------------------------------
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int N_MAX          = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic                 clk,
  input logic                 rst,
  uart_frame_parser_if.master bus
);

  parser_state_e state_q, state_d;
  parser_cmd_e   cmd_q, cmd_d;
  parser_err_e   code_q, code_d, abort_code;
  data_t         len_q, len_d;
  data_t         left_q, left_d;
  data_t         cnt_a_q, cnt_a_d;
  data_t         cnt_b_q, cnt_b_d;
  data_t         data_q, data_d;
  logic [3:0]    n_q, n_d;
  logic [3:0]    setn_q, setn_d;
  logic          push_a_q, push_a_d;
  logic          push_b_q, push_b_d;
  logic          start_q, start_d;
  logic          err_q, err_d;
  logic          abort;
  logic          busy;
  logic          timeout_expire;
  data_t         n8;

  assign busy = (state_q != ST_WAIT_HDR);
  assign n8   = {4'b0000, n_q};

`ifdef PARSER_TIMEOUT_EN
  byte_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .load   (bus.rx_valid),
    .enable (busy),
    .expire (timeout_expire)
  );
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
  assign timeout_expire = 1'b0;
`endif

  // Next-state and output decode. Each accepted byte moves the frame along;
  // every rejection funnels through 'abort' so the err pulse, sticky code and
  // return to WAIT_HDR are handled in one place. SET_N and START only act on
  // a correct tail byte, so the processor never sees half a command.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    code_d     = code_q;
    len_d      = len_q;
    left_d     = left_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    data_d     = data_q;
    n_d        = n_q;
    setn_d     = setn_q;
    push_a_d   = 1'b0;
    push_b_d   = 1'b0;
    start_d    = 1'b0;
    err_d      = 1'b0;
    abort      = 1'b0;
    abort_code = ERR_NONE;

    if (bus.rx_valid) begin
      case (state_q)
        ST_WAIT_HDR: begin
          if (bus.rx_data == FRAME_HDR) begin
            state_d = ST_GET_LEN;
            code_d  = ERR_NONE;
          end
        end
        ST_GET_LEN: begin
          len_d   = bus.rx_data;
          state_d = ST_GET_CMD;
        end
        ST_GET_CMD: begin
          if (!cmd_known(bus.rx_data)) begin
            abort      = 1'b1;
            abort_code = ERR_BAD_CMD;
          end else if (len_q != expected_len(bus.rx_data, n_q)) begin
            abort      = 1'b1;
            abort_code = ERR_BAD_LEN;
          end else if ((bus.rx_data == CMD_LOAD_A || bus.rx_data == CMD_LOAD_B) && n_q == 4'd0) begin
            abort      = 1'b1;
            abort_code = ERR_BAD_N;
          end else begin
            cmd_d   = parser_cmd_e'(bus.rx_data);
            left_d  = len_q - 8'd1;
            state_d = (len_q == 8'd1) ? ST_GET_END : ST_GET_DATA;
          end
        end
        ST_GET_DATA: begin
          left_d = left_q - 8'd1;
          if (left_q == 8'd1) begin
            state_d = ST_GET_END;
          end
          case (cmd_q)
            CMD_SET_N: begin
              if (bus.rx_data == 8'd0 || bus.rx_data > 8'(N_MAX)) begin
                abort      = 1'b1;
                abort_code = ERR_BAD_N;
              end else begin
                setn_d = bus.rx_data[3:0];
              end
            end
            CMD_LOAD_B: begin
              if (bus.full_B) begin
                abort      = 1'b1;
                abort_code = ERR_FULL;
              end else begin
                push_b_d = 1'b1;
                data_d   = bus.rx_data;
                cnt_b_d  = cnt_b_q + 8'd1;
              end
            end
            CMD_LOAD_A: begin
              if (bus.full_A) begin
                abort      = 1'b1;
                abort_code = ERR_FULL;
              end else begin
                push_a_d = 1'b1;
                data_d   = bus.rx_data;
                cnt_a_d  = cnt_a_q + 8'd1;
              end
            end
            default: begin
            end
          endcase
        end
        ST_GET_END: begin
          state_d = ST_WAIT_HDR;
          if (bus.rx_data != FRAME_END) begin
            abort      = 1'b1;
            abort_code = ERR_BAD_END;
          end else begin
            case (cmd_q)
              CMD_SET_N: begin
                n_d     = setn_q;
                cnt_a_d = 8'd0;
                cnt_b_d = 8'd0;
              end
              CMD_START: begin
                if (bus.proc_ready && cnt_a_q == (n8 * n8) && cnt_b_q == n8) begin
                  start_d = 1'b1;
                  cnt_a_d = 8'd0;
                  cnt_b_d = 8'd0;
                end else begin
                  abort      = 1'b1;
                  abort_code = ERR_NOT_READY;
                end
              end
              default: begin
              end
            endcase
          end
        end
        default: state_d = ST_WAIT_HDR;
      endcase
    end else if (timeout_expire) begin
      abort      = 1'b1;
      abort_code = ERR_TIMEOUT;
    end

    if (abort) begin
      state_d = ST_WAIT_HDR;
      err_d   = 1'b1;
      code_d  = abort_code;
    end
  end

  // State and registered outputs. Reset drops any open frame silently and
  // forgets the matrix order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_WAIT_HDR;
      cmd_q    <= CMD_START;
      code_q   <= ERR_NONE;
      len_q    <= 8'd0;
      left_q   <= 8'd0;
      cnt_a_q  <= 8'd0;
      cnt_b_q  <= 8'd0;
      data_q   <= 8'd0;
      n_q      <= 4'd0;
      setn_q   <= 4'd0;
      push_a_q <= 1'b0;
      push_b_q <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      code_q   <= code_d;
      len_q    <= len_d;
      left_q   <= left_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      data_q   <= data_d;
      n_q      <= n_d;
      setn_q   <= setn_d;
      push_a_q <= push_a_d;
      push_b_q <= push_b_d;
      start_q  <= start_d;
      err_q    <= err_d;
    end
  end

  assign bus.push_A   = push_a_q;
  assign bus.push_B   = push_b_q;
  assign bus.data     = data_q;
  assign bus.N        = n_q;
  assign bus.start    = start_q;
  assign bus.busy     = busy;
  assign bus.err      = err_q;
  assign bus.err_code = code_q;

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level command parser sitting directly upstream of the matrix-vector processor top level. It consumes bytes from the UART receiver and decodes framed commands. It drives the processor's `push_A`/`push_B` FIFO writes with their shared `data` bus, the matrix order `N`, and the one-cycle `start` strobe. Malformed or out-of-order frames are rejected with an error code, and the processor never sees a partial start.

## Interface
Parameters:
- `N_MAX`, default 8: largest legal matrix order. `N*N+1` must fit in 8 bits.
- `TIMEOUT_CYCLES`, default 50000: inter-byte timeout in clk cycles. Used only with `PARSER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rx_data`  in  data_t (8)  received byte
- `rx_valid`  in  1  one-cycle strobe; `rx_data` valid this cycle
- `full_A`  in  1  FIFO A full
- `full_B`  in  1  FIFO B full
- `proc_ready`  in  1  processor idle, able to accept `start`
- `push_A`  out  1  write `data` into FIFO A
- `push_B`  out  1  write `data` into FIFO B
- `data`  out  data_t (8)  payload byte for FIFO A/B
- `N`  out  4  current matrix order; 0 = unset
- `start`  out  1  one-cycle start pulse
- `busy`  out  1  frame in progress (state ≠ WAIT_HDR)
- `err`  out  1  one-cycle pulse on frame abort
- `err_code`  out  3  sticky code of last error; cleared on next header byte

## Operation
- Frame format: `0xFE`, `L`, `CMD`, payload (`L-1` bytes), `0xEF`. `L` counts CMD plus payload.
- Commands:
  - `0x01` SET_N: `L=2`. Payload 1..`N_MAX` loads `N` and clears `cnt_a`/`cnt_b`. Any other value → BAD_N, `N` unchanged.
  - `0x02` START: `L=1`.
  - `0x03` LOAD_B: `L=N+1`. Each payload byte pushes to B; `cnt_b++`.
  - `0x04` LOAD_A: `L=N*N+1`. Each payload byte pushes to A; `cnt_a++`.
- States: WAIT_HDR → GET_LEN → GET_CMD → GET_DATA (skipped when `L=1`) → GET_END → WAIT_HDR.
  - WAIT_HDR ignores every byte except `0xFE`.
- Validation and error codes (every error pulses `err`, sets `err_code`, returns to WAIT_HDR):
  - At GET_CMD: unknown CMD → BAD_CMD (2). `L` mismatch → BAD_LEN (1). LOAD_A/LOAD_B with `N=0` → BAD_N (7).
  - In GET_DATA: FIFO full on a payload byte → byte dropped, FULL (4).
  - At GET_END: byte ≠ `0xEF` → BAD_END (3).
  - START at a valid tail without `proc_ready`, `cnt_a=N*N` and `cnt_b=N` → NOT_READY (5).
- Bytes already pushed before an abort stay in the FIFOs. Counters keep their value.
- SET_N takes effect, and START fires, only at a valid tail byte.
- A valid START clears `cnt_a`/`cnt_b`.

## Timing
- Reset values: all outputs 0, `N=0`, counters 0, state WAIT_HDR.
- Reset mid-frame aborts silently: no `err`, and `N` returns to 0.
- `rx_valid` at byte t → state advances at t+1.
- Payload push: `push_X` and `data` are registered and asserted at t+1 for exactly one cycle.
- `start`: asserted the cycle after the tail byte, one cycle only.
- `err`: asserted the cycle after the offending byte.
- Back-to-back `rx_valid` on every cycle is supported.
- FIFO full is sampled in the same cycle as `rx_valid`. A push is never issued while full.

## Configuration
- `PARSER_TIMEOUT_EN` defined:
  - Counter restarts on every `rx_valid` while `busy`.
  - Reaching `TIMEOUT_CYCLES` aborts the frame with TIMEOUT (6) and pulses `err`.
- Undefined: no counter; the parser waits indefinitely mid-frame and code 6 is never produced.

## Structure
- `fifo_pkg` additions:
  - constants `FRAME_HDR=8'hFE`, `FRAME_END=8'hEF`
  - `parser_cmd_e` enum
  - `parser_state_e` enum
  - `parser_err_e` (3-bit)
- Reuse `data_t`.
- One sub-module, `byte_timeout_counter` (load/expire), instantiated only under `PARSER_TIMEOUT_EN`.

## Test plan
- SET_N `FE 02 01 03 EF` → `N=3` one cycle after `EF`. No `err`, no push.
- With N=3, LOAD_B `FE 04 03 0A 0B 0C EF` → three `push_B` pulses, `data` 0A/0B/0C. Then LOAD_A with 9 bytes 01..09 → nine `push_A` pulses.
- START `FE 01 02 EF` with `proc_ready=1` after full load → single `start` pulse. Repeating START immediately → NOT_READY (5), no `start`.
- LOAD_B with `L=05` while N=3 → `err`, `err_code=1` after CMD byte. Following payload bytes ignored until next `FE`.
- `full_A` high during 2nd LOAD_A payload byte → byte not pushed, `err_code=4`. Tail `AA` in another frame → `err_code=3`.
- Reset asserted mid-LOAD_A → outputs 0, `N=0`. With `PARSER_TIMEOUT_EN`, stalling after `FE 02` for `TIMEOUT_CYCLES` → `err`, `err_code=6`.
